board_point_writer: RTL and testbench
=====================================

# board_point_writer

Write-side owner of the 16x16 game board: accepts single-point placement requests (x row, y column, piece colour) through a valid/ready handshake, checks legality, inserts the 2-bit point code into the addressed 32-bit row, and supports a sequenced full-board clear. It sits between the game controller, which issues moves, and the per-row read path, which consumes `rd_row` and extracts one point by y-coordinate.

## Interface
- `BOARD_DIM`, 16: rows and points per row; fixed at 16, widths below assume it.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  placement request valid.
- `wr_ready`  out  1  block can accept a request.
- `wr_x`  in  4  row index.
- `wr_y`  in  4  point index within the row; point y occupies bits [2y+1:2y].
- `wr_color`  in  2  00 empty, 01 black, 10 white, 11 reserved.
- `clr_start`  in  1  start full-board clear; sampled only in IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a request or clear finishes.
- `status`  out  2  00 ok, 01 occupied, 10 illegal colour; valid while `done`=1.
- `move_count`  out  9  number of occupied points, 0..256.
- `rd_x`  in  4  row to read.
- `rd_row`  out  32  registered contents of row `rd_x`.

## Operation
- Storage: 16 registers of 32 bits, all 0 after reset.
- States: IDLE, CHECK, RESP, CLEAR.
- IDLE: `wr_ready`=1 unless `clr_start`=1. `clr_start` has priority over `wr_valid` in the same cycle: the block goes to CLEAR, and the write is not accepted. If `wr_valid`=1 and `wr_ready`=1, the block latches x/y/colour and goes to CHECK.
- CHECK: the block reads the target point.
  - Colour 00 or 11: status 10, no write.
  - Point non-zero with the guard enabled: status 01, no write.
  - Otherwise: the block writes the colour into the point, and status is 00.
  - `move_count` increments only when an empty point becomes non-empty.
  - The block always goes to RESP next.
- RESP: `done`=1 and `status` is driven. The block then returns to IDLE.
- CLEAR: a 4-bit row counter starts at 0 and zeroes one row per cycle (rows 0..15, 16 cycles). After row 15 the block goes to RESP with status 00, and `move_count` becomes 0.
- `rd_row` is updated every cycle from `rd_x`, independent of state.

## Timing
- Reset values: state IDLE, `wr_ready`=1, `busy`=0, `done`=0, `status`=00, `move_count`=0, `rd_row`=0, board all zero.
- Write latency:
  - Accept at edge N.
  - The row register updates at edge N+1 (end of CHECK).
  - `done` is high during cycle N+2, the cycle after the N+1 edge.
  - The next request can be accepted at edge N+3.
- Clear: accepted at edge N; rows written at edges N+1..N+16; `done` high in the cycle after N+16.
- Read latency: 1 cycle. A read of the row being written in the same cycle returns the old value; the new value appears one cycle later.
- `wr_ready`=0 in CHECK, RESP and CLEAR. A requester must hold `wr_valid` with stable fields until accepted.
- A reset asserted mid-write or mid-clear aborts the operation: the board is zeroed and no `done` pulse follows.
- The counter cannot exceed 256: every increment requires an empty point, and there are 256 points.

## Configuration
- `OVERWRITE_GUARD_EN` defined: a write to an occupied point is rejected with status 01, leaving the board and count unchanged.
- Macro undefined: an occupied point is overwritten with the new legal colour, status 00, and `move_count` is unchanged. Status 01 is never produced.

## Structure
- Package `board_pkg`:
  - `BOARD_DIM`
  - point codes EMPTY/BLACK/WHITE/RSVD
  - status codes ST_OK/ST_OCCUPIED/ST_ILLEGAL
  - state enum `writer_state_t`
- Sub-module `y_coordinate_select_write`: combinational. Inputs are a 32-bit row, a 4-bit y and a 2-bit value; output is the row with only that point replaced. It is the insert counterpart of the per-row read selector.

## Test plan
- After reset, write x=3, y=5, colour 01 → `done` pulse 2 cycles after accept, status 00, `move_count`=1; `rd_x`=3 gives `rd_row`=0x0000_0400.
- Repeat x=3, y=5, colour 10:
  - with the guard → status 01, row still 0x0000_0400, count 1;
  - without the guard → status 00, row 0x0000_0800, count 1.
- Write colour 11 at x=0, y=0 → status 10, row 0 stays 0, count unchanged.
- Fill x=15, y=15 with 10 and x=0, y=0 with 01, then `clr_start` → `busy` for 17 cycles, `done` with status 00, all rows 0, count 0.
- Assert `clr_start` and `wr_valid` together in IDLE → the clear runs, the write is not accepted and stays pending until after `done`.
- Assert reset during cycle 8 of a clear → next cycle is IDLE, board all zero, `done` never pulses.

Source files
------------

// File: rtl/board_pkg.sv
// Shared definitions for the 16x16 board write path: dimensions, point codes,
// response status codes, writer FSM states and the latched request.
package board_pkg;

  localparam int BOARD_DIM = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10,
    RSVD  = 2'b11
  } point_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_OCCUPIED = 2'b01,
    ST_ILLEGAL  = 2'b10
  } status_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESP,
    CLEAR
  } writer_state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] color;
  } wr_req_t;

endpackage

// File: rtl/y_coordinate_select_write.sv
// Point insert: returns the row with only point y (bits [2y+1:2y]) replaced.
// Mirror of the per-row read selector used on the read path.
module y_coordinate_select_write
  import board_pkg::*;
(
  input  logic [2*BOARD_DIM-1:0] row,
  input  logic [3:0]             y,
  input  logic [1:0]             value,
  output logic [2*BOARD_DIM-1:0] new_row
);

  // Copy the row, then overwrite the addressed 2-bit point
  always_comb begin
    new_row = row;
    new_row[{y, 1'b0} +: 2] = value;
  end

endmodule

// File: rtl/board_point_writer.sv
// Write-side owner of the 16x16 board. Accepts single-point placements over
// valid/ready, checks legality, inserts the point, and runs a 16-cycle
// sequenced clear. Optional macro OVERWRITE_GUARD_EN rejects writes to
// occupied points with status 01; without it occupied points are overwritten.
module board_point_writer
  import board_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [3:0]             wr_x,
  input  logic [3:0]             wr_y,
  input  logic [1:0]             wr_color,
  input  logic                   clr_start,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [8:0]             move_count,
  input  logic [3:0]             rd_x,
  output logic [2*BOARD_DIM-1:0] rd_row
);

`ifdef OVERWRITE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  writer_state_t state, state_nxt;
  wr_req_t       req;
  logic [BOARD_DIM-1:0][2*BOARD_DIM-1:0] board;
  logic [3:0]    clr_row;
  logic [8:0]    cnt;
  logic [1:0]    st_q;

  logic [2*BOARD_DIM-1:0] cur_row, ins_row;
  logic [1:0] cur_pt;
  logic       illegal, occupied, do_write, accept;
  logic [1:0] chk_status;

  assign cur_row = board[req.x];
  assign cur_pt  = cur_row[{req.y, 1'b0} +: 2];

  y_coordinate_select_write u_ins (
    .row     (cur_row),
    .y       (req.y),
    .value   (req.color),
    .new_row (ins_row)
  );

  // Legality of the latched request against the current point
  always_comb begin
    illegal    = (req.color == EMPTY) || (req.color == RSVD);
    occupied   = (cur_pt != EMPTY);
    do_write   = !illegal && !(GUARD && occupied);
    chk_status = ST_OK;
    if (illegal)                chk_status = ST_ILLEGAL;
    else if (GUARD && occupied) chk_status = ST_OCCUPIED;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs; clear request wins over a write in IDLE
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (clr_start) state_nxt = CLEAR;
        else begin
          wr_ready = 1'b1;
          if (wr_valid) state_nxt = CHECK;
        end
      end
      CHECK: state_nxt = RESP;
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      CLEAR: if (clr_row == 4'd15) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = wr_ready && wr_valid;
  assign status     = st_q;
  assign move_count = cnt;

  // Board storage, request latch, occupancy counter and clear sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      board   <= '0;
      req     <= '0;
      cnt     <= '0;
      st_q    <= ST_OK;
      clr_row <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept)    req     <= '{x: wr_x, y: wr_y, color: wr_color};
          if (clr_start) clr_row <= '0;
        end
        CHECK: begin
          if (do_write) board[req.x] <= ins_row;
          // Count only empty->occupied transitions; overwrites leave it alone
          if (do_write && !occupied) cnt <= cnt + 9'd1;
          st_q <= chk_status;
        end
        CLEAR: begin
          board[clr_row] <= '0;
          clr_row        <= clr_row + 4'd1;
          if (clr_row == 4'd15) begin
            cnt  <= '0;
            st_q <= ST_OK;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered row read; a same-cycle write is seen one cycle later
  always_ff @(posedge clk) begin
    if (reset) rd_row <= '0;
    else       rd_row <= board[rd_x];
  end

endmodule

// File: tb/tb_board_point_writer.sv
// Scoreboard bench for board_point_writer: stimulus pushes expected responses,
// a negedge monitor pops and checks on every done pulse.
module tb_board_point_writer;

`ifdef OVERWRITE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, wr_valid, wr_ready, clr_start, busy, done;
  logic [3:0]  wr_x, wr_y, rd_x;
  logic [1:0]  wr_color, status;
  logic [8:0]  move_count;
  logic [31:0] rd_row;

  board_point_writer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .clr_start(clr_start),
    .busy(busy), .done(done), .status(status), .move_count(move_count),
    .rd_x(rd_x), .rd_row(rd_row)
  );

  always #5 clk = ~clk;

  int npass = 0, nchk = 0, cyc = 0, last_done = -1;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] st;
    logic [8:0] cnt;
    int         due;
  } exp_t;
  exp_t q[$];
  exp_t e;

  // Reference board: one colour code per point plus an occupancy count
  logic [1:0] pts[16][16];
  int mcnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mrow(int x);
    logic [31:0] r = '0;
    for (int y = 0; y < 16; y++) r = r | (32'(pts[x][y]) << (2 * y));
    return r;
  endfunction

  task automatic model_clear();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) pts[x][y] = 2'b00;
    mcnt = 0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      last_done = cyc;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("status", status, e.st);
        chk("move_count", move_count, e.cnt);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  // Fields already driven with wr_valid=1; waits for acceptance, then scores it
  task automatic send_write(output int acc);
    logic ok = 1'b0;
    int n = 0;
    logic [1:0] st;
    exp_t it;
    acc = -1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = wr_ready;
      @(posedge clk);
      n++;
    end
    #1 wr_valid = 1'b0;
    if (!ok) begin chk("accept_timeout", 1, 0); return; end
    if (wr_color == 2'b00 || wr_color == 2'b11) st = 2'b10;
    else if (pts[wr_x][wr_y] != 2'b00 && GUARD) st = 2'b01;
    else begin
      if (pts[wr_x][wr_y] == 2'b00) mcnt++;
      pts[wr_x][wr_y] = wr_color;
      st = 2'b00;
    end
    @(negedge clk);
    acc = cyc;
    it.st = st; it.cnt = 9'(mcnt); it.due = cyc + 1;
    q.push_back(it);
  endtask

  task automatic do_write(int x, int y, int c);
    int acc;
    @(posedge clk); #1;
    wr_x = 4'(x); wr_y = 4'(y); wr_color = 2'(c); wr_valid = 1'b1;
    send_write(acc);
    wait_idle();
  endtask

  task automatic do_clear();
    exp_t it;
    int nb = 0;
    @(posedge clk); #1 clr_start = 1'b1;
    @(negedge clk); chk("clear_start_idle", busy, 0);
    @(posedge clk); #1 clr_start = 1'b0;
    model_clear();
    @(negedge clk);
    it.st = 2'b00; it.cnt = 9'd0; it.due = cyc + 16;
    q.push_back(it);
    while (busy && nb < 100) begin nb++; @(negedge clk); end
    chk("clear_busy_cycles", nb, 17);
  endtask

  task automatic check_row(int x);
    @(posedge clk); #1 rd_x = 4'(x);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rd_row[%0d]", x), rd_row, mrow(x));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    exp_t it;
    reset = 1'b1; wr_valid = 1'b0; clr_start = 1'b0;
    wr_x = '0; wr_y = '0; wr_color = '0; rd_x = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_status", status, 0);
    chk("reset_count", move_count, 0);
    chk("reset_rd_row", rd_row, 0);

    // Directed placements
    do_write(3, 5, 1);
    check_row(3);
    chk("row3_first_write", rd_row, 32'h0000_0400);
    do_write(3, 5, 2);
    check_row(3);
    chk("row3_second_write", rd_row, GUARD ? 32'h0000_0400 : 32'h0000_0800);
    do_write(0, 0, 3);
    check_row(0);
    do_write(15, 15, 2);
    do_write(0, 0, 1);
    check_row(15);
    check_row(0);
    do_clear();
    for (int x = 0; x < 16; x++) check_row(x);
    chk("count_after_clear", move_count, 0);

    // Clear and write requested together: clear first, write waits
    do_write(7, 9, 1);
    @(posedge clk); #1;
    wr_x = 4'd2; wr_y = 4'd14; wr_color = 2'b10; wr_valid = 1'b1; clr_start = 1'b1;
    @(negedge clk); chk("ready_low_on_clr", wr_ready, 0);
    @(posedge clk); #1 clr_start = 1'b0;
    model_clear();
    @(negedge clk);
    it.st = 2'b00; it.cnt = 9'd0; it.due = cyc + 16;
    q.push_back(it);
    send_write(acc);
    chk("write_after_clear_done", acc > last_done && last_done >= 0, 1);
    wait_idle();
    check_row(2);
    check_row(7);

    // Randomized placements, biased toward a few rows to hit occupied points
    for (int i = 0; i < 60; i++) begin
      int x = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
      do_write(x, $urandom_range(0, 15), $urandom_range(0, 3));
    end
    do_write(15, 15, 1);
    for (int x = 0; x < 16; x++) check_row(x);

    // Reset in the 8th cycle of a clear: abort, board zero, no done
    @(posedge clk); #1 clr_start = 1'b1;
    @(posedge clk); #1 clr_start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready", wr_ready, 1);
    chk("abort_count", move_count, 0);
    model_clear();
    repeat (30) @(negedge clk);
    for (int x = 0; x < 16; x++) check_row(x);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
